// File: rtl/store_narrow.sv
// store_narrow: memory-stage store unit for the pipelined MIPS core.
//
// Places an sw/sh/sb operand into its big-endian lane of a 32-bit word.
// Word stores are written directly. Halfword and byte stores use a
// read-modify-write sequence on the word-only data memory. busy stalls
// IF/ID/EX while a store is in flight. Every output is a flop that is
// loaded from the next-state decode, so no st_* input reaches a mem_*
// strobe through combinational logic.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   st_valid   store request present in the MEM stage
//   st_size    00 sw, 01 sh, 10 sb, 11 reserved (always rejected)
//   st_addr    byte address of the store
//   st_data    rt value; only the low 8/16 bits are used for sb/sh
//   busy       high in every state except IDLE
//   mem_addr   latched word address while active, 0 in IDLE
//   mem_rd     one-cycle read strobe (READ state)
//   mem_rdata  synchronous read data, valid one cycle after mem_rd
//   mem_wr     one-cycle write strobe (WRITE state)
//   mem_wdata  merged write word (WRITE state), otherwise 0
//   mem_be     byte enables, bit 3 = bits 31:24 (WRITE state), otherwise 0
//   done       one-cycle pulse together with mem_wr
//   misalign   one-cycle pulse after a rejected request
module store_narrow #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              misalign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // True when the offset satisfies the alignment rule of the size code.
  function automatic logic size_ok(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   size_ok = (off == 2'b00);
      2'b01:   size_ok = (off[0] == 1'b0);
      2'b10:   size_ok = 1'b1;
      default: size_ok = 1'b0;
    endcase
  endfunction

  // Byte enables of the big-endian lane(s) a store touches.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_be = 4'b1111;
      2'b01:   lane_be = off[1] ? 4'b0011 : 4'b1100;
      2'b10:   lane_be = 4'b1000 >> off;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  // Store operand shifted into its lane; bytes outside the lane are zero.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] data);
    case (size)
      2'b00:   lane_data = data;
      2'b01:   lane_data = off[1] ? {16'h0000, data[15:0]} : {data[15:0], 16'h0000};
      2'b10:   lane_data = {data[7:0], 24'h000000} >> {off, 3'b000};
      default: lane_data = 32'h0000_0000;
    endcase
  endfunction

  // Overwrite the enabled bytes of the memory word with the lane data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] lane,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    merge = (old & ~mask) | (lane & mask);
  endfunction

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   addr_r, addr_next_s;
  logic [3:0]          be_r, be_next_s;
  logic [31:0]         lane_r, lane_next_s;
  logic [31:0]         wbuf_r, wbuf_next_s;
  logic                misalign_next_s;

  // Next-state decode and update of the latched request fields.
  always_comb begin
    state_next_s    = state_r;
    addr_next_s     = addr_r;
    be_next_s       = be_r;
    lane_next_s     = lane_r;
    wbuf_next_s     = wbuf_r;
    misalign_next_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (st_valid) begin
          if (size_ok(st_size, st_addr[1:0])) begin
            addr_next_s = {st_addr[ADDR_W-1:2], 2'b00};
            be_next_s   = lane_be(st_size, st_addr[1:0]);
            lane_next_s = lane_data(st_size, st_addr[1:0], st_data);
            if (st_size == 2'b00) begin
              // A full word needs no read; it is written as is.
              wbuf_next_s  = st_data;
              state_next_s = S_WRITE;
            end else begin
              state_next_s = S_READ;
            end
          end else begin
            misalign_next_s = 1'b1;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_READ:  state_next_s = S_WAIT;
      S_WAIT: begin
        // mem_rdata answers the READ-cycle strobe here.
        wbuf_next_s  = merge(mem_rdata, lane_r, be_r);
        state_next_s = S_WRITE;
      end
      S_WRITE: state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      be_r    <= 4'b0000;
      lane_r  <= 32'h0000_0000;
      wbuf_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      addr_r  <= addr_next_s;
      be_r    <= be_next_s;
      lane_r  <= lane_next_s;
      wbuf_r  <= wbuf_next_s;
    end
  end

  // Output flops loaded from the decode of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
    end else begin
      busy      <= (state_next_s != S_IDLE);
      mem_rd    <= (state_next_s == S_READ);
      mem_wr    <= (state_next_s == S_WRITE);
      done      <= (state_next_s == S_WRITE);
      misalign  <= misalign_next_s;
      mem_addr  <= (state_next_s != S_IDLE) ? addr_next_s : {ADDR_W{1'b0}};
      mem_wdata <= (state_next_s == S_WRITE) ? wbuf_next_s : 32'h0000_0000;
      mem_be    <= (state_next_s == S_WRITE) ? be_next_s : 4'b0000;
    end
  end

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow: directed vector table, randomized
// stores against a byte-level reference model, a reset abort and a
// stalled back-to-back pair. Outputs are logged per cycle at the falling
// edge and checked against expected values after each operation.
module tb_store_narrow;

  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [1:0]  st_size = 2'b00;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy, mem_rd, mem_wr, done, misalign;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  store_narrow #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .busy(busy), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .done(done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        lg_busy [LOGN];
  logic        lg_rd   [LOGN];
  logic        lg_wr   [LOGN];
  logic        lg_done [LOGN];
  logic        lg_mis  [LOGN];
  logic [31:0] lg_addr [LOGN];
  logic [31:0] lg_wd   [LOGN];
  logic [3:0]  lg_be   [LOGN];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      lg_busy[cyc] = busy;    lg_rd[cyc] = mem_rd;  lg_wr[cyc] = mem_wr;
      lg_done[cyc] = done;    lg_mis[cyc] = misalign;
      lg_addr[cyc] = mem_addr; lg_wd[cyc] = mem_wdata; lg_be[cyc] = mem_be;
    end
  end

  // Word-only synchronous data memory; unwritten words hold a hash pattern.
  logic [31:0] ram [int];
  logic [31:0] wtmp;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    if (ram.exists(k)) return ram[k];
    else return ({a[31:2], 2'b00} * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram_rd(mem_addr);
    if (mem_wr) begin
      wtmp = ram_rd(mem_addr);
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) wtmp[8*i +: 8] = mem_wdata[8*i +: 8];
      ram[int'(mem_addr >> 2)] = wtmp;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: split the old word into big-endian bytes, replace the stored ones.
  function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a,
                                    input logic [31:0] d, input logic [31:0] old,
                                    output logic mis, output logic [31:0] w,
                                    output logic [3:0] be);
    logic [7:0] b [4];
    int off;
    off = int'(a[1:0]);
    mis = 1'b0;
    be  = 4'b0000;
    for (int i = 0; i < 4; i++) b[i] = old[31-8*i -: 8];
    case (sz)
      2'b00: if (off != 0) mis = 1'b1;
             else for (int i = 0; i < 4; i++) begin b[i] = d[31-8*i -: 8]; be[3-i] = 1'b1; end
      2'b01: if (off % 2 != 0) mis = 1'b1;
             else begin
               b[off] = d[15:8]; b[off+1] = d[7:0];
               be[3-off] = 1'b1; be[2-off] = 1'b1;
             end
      2'b10: begin b[off] = d[7:0]; be[3-off] = 1'b1; end
      default: mis = 1'b1;
    endcase
    w = {b[0], b[1], b[2], b[3]};
  endfunction

  // Present one request for a single cycle; b is the cycle before acceptance.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       output int b);
    @(posedge clk); #1;
    st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
    b = cyc;
    @(posedge clk); #1;
    st_valid = 1'b0; st_size = 2'($urandom); st_addr = $urandom; st_data = $urandom;
  endtask

  task automatic check_op(input string tag, input int b, input logic mis, input logic [1:0] sz,
                          input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] ebe);
    while (cyc < b + 6) @(posedge clk);
    chk({tag, ".busy0"}, 32'(lg_busy[b]), 32'd0);
    if (mis) begin
      chk({tag, ".mis1"},  32'(lg_mis[b+1]),  32'd1);
      chk({tag, ".busy1"}, 32'(lg_busy[b+1]), 32'd0);
      chk({tag, ".rd1"},   32'(lg_rd[b+1]),   32'd0);
      chk({tag, ".wr1"},   32'(lg_wr[b+1]),   32'd0);
      chk({tag, ".mis2"},  32'(lg_mis[b+2]),  32'd0);
      chk({tag, ".busy2"}, 32'(lg_busy[b+2]), 32'd0);
      chk({tag, ".wr2"},   32'(lg_wr[b+2]),   32'd0);
    end else if (sz == 2'b00) begin
      chk({tag, ".busy1"}, 32'(lg_busy[b+1]), 32'd1);
      chk({tag, ".wr1"},   32'(lg_wr[b+1]),   32'd1);
      chk({tag, ".done1"}, 32'(lg_done[b+1]), 32'd1);
      chk({tag, ".rd1"},   32'(lg_rd[b+1]),   32'd0);
      chk({tag, ".mis1"},  32'(lg_mis[b+1]),  32'd0);
      chk({tag, ".addr1"}, lg_addr[b+1], ea);
      chk({tag, ".wd1"},   lg_wd[b+1],   ew);
      chk({tag, ".be1"},   32'(lg_be[b+1]), 32'(ebe));
      chk({tag, ".busy2"}, 32'(lg_busy[b+2]), 32'd0);
      chk({tag, ".wr2"},   32'(lg_wr[b+2]),   32'd0);
      chk({tag, ".rd2"},   32'(lg_rd[b+2]),   32'd0);
    end else begin
      chk({tag, ".rd1"},   32'(lg_rd[b+1]),   32'd1);
      chk({tag, ".busy1"}, 32'(lg_busy[b+1]), 32'd1);
      chk({tag, ".wr1"},   32'(lg_wr[b+1]),   32'd0);
      chk({tag, ".mis1"},  32'(lg_mis[b+1]),  32'd0);
      chk({tag, ".addr1"}, lg_addr[b+1], ea);
      chk({tag, ".busy2"}, 32'(lg_busy[b+2]), 32'd1);
      chk({tag, ".rd2"},   32'(lg_rd[b+2]),   32'd0);
      chk({tag, ".wr2"},   32'(lg_wr[b+2]),   32'd0);
      chk({tag, ".wr3"},   32'(lg_wr[b+3]),   32'd1);
      chk({tag, ".done3"}, 32'(lg_done[b+3]), 32'd1);
      chk({tag, ".busy3"}, 32'(lg_busy[b+3]), 32'd1);
      chk({tag, ".addr3"}, lg_addr[b+3], ea);
      chk({tag, ".wd3"},   lg_wd[b+3],   ew);
      chk({tag, ".be3"},   32'(lg_be[b+3]), 32'(ebe));
      chk({tag, ".busy4"}, 32'(lg_busy[b+4]), 32'd0);
      chk({tag, ".wr4"},   32'(lg_wr[b+4]),   32'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] memw;
    logic        mis;
    logic [31:0] ew;
    logic [3:0]  ebe;
  } vec_t;

  vec_t tbl [8];

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : main
    int b;
    logic        rmis;
    logic [31:0] rw, old;
    logic [3:0]  rbe;
    logic [1:0]  sz;
    logic [31:0] a, d;

    tbl[0] = '{2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 4'b1111};
    tbl[1] = '{2'b10, 32'h0000_0021, 32'h0000_00AB, 32'h1122_3344, 1'b0, 32'h11AB_3344, 4'b0100};
    tbl[2] = '{2'b01, 32'h0000_0042, 32'h0000_CAFE, 32'h5566_7788, 1'b0, 32'h5566_CAFE, 4'b0011};
    tbl[3] = '{2'b01, 32'h0000_0003, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000};
    tbl[4] = '{2'b00, 32'h0000_0006, 32'h0BAD_F00D, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000};
    tbl[5] = '{2'b11, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000};
    tbl[6] = '{2'b10, 32'h0000_0013, 32'hFFFF_FF5A, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BE5A, 4'b0001};
    tbl[7] = '{2'b01, 32'h0000_0050, 32'h1234_ABCD, 32'h0000_0000, 1'b0, 32'hABCD_0000, 4'b1100};

    // Reset state.
    #12;
    chk("rst.busy", 32'(busy), 32'd0);    chk("rst.rd", 32'(mem_rd), 32'd0);
    chk("rst.wr", 32'(mem_wr), 32'd0);    chk("rst.done", 32'(done), 32'd0);
    chk("rst.mis", 32'(misalign), 32'd0); chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wd", mem_wdata, 32'd0);      chk("rst.be", 32'(mem_be), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].mis) ram[int'(tbl[i].a >> 2)] = tbl[i].memw;
      issue(tbl[i].sz, tbl[i].a, tbl[i].d, b);
      check_op($sformatf("vec%0d", i), b, tbl[i].mis, tbl[i].sz,
               {tbl[i].a[31:2], 2'b00}, tbl[i].ew, tbl[i].ebe);
    end

    // Randomized stores against the reference model.
    for (int n = 0; n < 150; n++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = 32'($urandom_range(0, 63));
      d   = $urandom;
      old = ram_rd(a);
      ref_store(sz, a, d, old, rmis, rw, rbe);
      issue(sz, a, d, b);
      check_op($sformatf("rnd%0d", n), b, rmis, sz, {a[31:2], 2'b00}, rw, rbe);
    end

    // Reset while in WAIT aborts the store.
    ram[int'(32'h30 >> 2)] = 32'hCAFE_F00D;
    issue(2'b10, 32'h0000_0031, 32'h0000_0077, b);
    @(posedge clk); #2;
    chk("abort.busy_wait", 32'(busy), 32'd1);
    rst = 1'b0; #1;
    chk("abort.busy", 32'(busy), 32'd0);    chk("abort.rd", 32'(mem_rd), 32'd0);
    chk("abort.wr", 32'(mem_wr), 32'd0);    chk("abort.done", 32'(done), 32'd0);
    chk("abort.mis", 32'(misalign), 32'd0); chk("abort.addr", mem_addr, 32'd0);
    chk("abort.wd", mem_wdata, 32'd0);      chk("abort.be", 32'(mem_be), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    b = cyc;
    while (cyc < b + 8) @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("abort.post_wr%0d", k), 32'(lg_wr[b+k]), 32'd0);
      chk($sformatf("abort.post_busy%0d", k), 32'(lg_busy[b+k]), 32'd0);
    end
    chk("abort.ram", ram_rd(32'h30), 32'hCAFE_F00D);

    // Two byte stores, the second held by the stall until the first is done.
    ram[int'(32'h80 >> 2)] = 32'hA1B2_C3D4;
    @(posedge clk); #1;
    st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_0080; st_data = 32'h0000_0012;
    b = cyc;
    @(posedge clk); #1;
    st_addr = 32'h0000_0083; st_data = 32'h0000_0034;
    repeat (4) @(posedge clk);
    #1; st_valid = 1'b0;
    while (cyc < b + 10) @(posedge clk);
    chk("stall.rd1", 32'(lg_rd[b+1]), 32'd1);
    chk("stall.rd2", 32'(lg_rd[b+2]), 32'd0);
    chk("stall.wr2", 32'(lg_wr[b+2]), 32'd0);
    chk("stall.wr3", 32'(lg_wr[b+3]), 32'd1);
    chk("stall.be3", 32'(lg_be[b+3]), 32'b1000);
    chk("stall.wd3", lg_wd[b+3], 32'h12B2_C3D4);
    chk("stall.busy4", 32'(lg_busy[b+4]), 32'd0);
    chk("stall.rd4", 32'(lg_rd[b+4]), 32'd0);
    chk("stall.rd5", 32'(lg_rd[b+5]), 32'd1);
    chk("stall.addr5", lg_addr[b+5], 32'h0000_0080);
    chk("stall.wr6", 32'(lg_wr[b+6]), 32'd0);
    chk("stall.wr7", 32'(lg_wr[b+7]), 32'd1);
    chk("stall.be7", 32'(lg_be[b+7]), 32'b0001);
    chk("stall.wd7", lg_wd[b+7], 32'h12B2_C334);
    chk("stall.busy8", 32'(lg_busy[b+8]), 32'd0);
    chk("stall.wr8", 32'(lg_wr[b+8]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
